lmem_gather_scatter: RTL and testbench
======================================

LMEM_GATHER_SCATTER -- requirements
Module: lmem_gather_scatter

Interface
REQ-001 Parameter NUM_LANES, default 4: number of request lanes and number of memory banks; power of two, 2..16.
REQ-002 Parameter DEPTH_WORDS, default 1024: words per bank; power of two.
REQ-003 Parameter WORD_W, default 32: bits per bank word; multiple of 8.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_we  input  1  1 = scatter write, 0 = gather read, applies to all lanes.
REQ-009 req_lane_mask  input  NUM_LANES  per-lane active bit.
REQ-010 req_addr  input  NUM_LANES*32  per-lane byte address, lane i at bits [32*i +: 32].
REQ-011 req_wdata  input  NUM_LANES*WORD_W  per-lane write data.
REQ-012 req_be  input  NUM_LANES*WORD_W/8  per-lane byte enables, writes only.
REQ-013 resp_valid  output  1  one-cycle completion pulse.
REQ-014 resp_rdata  output  NUM_LANES*WORD_W  per-lane read data.

Function
REQ-015 The block SHALL map lane address A to bank = A[2 +: log2(NUM_LANES)] and index = A[2+log2(NUM_LANES) +: log2(DEPTH_WORDS)]; A[1:0] and upper bits are ignored.
REQ-016 The FSM SHALL have states IDLE, ISSUE and DRAIN; req_ready = (state == IDLE).
REQ-017 In IDLE, req_valid && req_ready SHALL latch all request fields and enter ISSUE; all lanes in the mask become pending.
REQ-018 In ISSUE, each bank SHALL grant the lowest-numbered pending lane targeting it, each cycle; granted lanes clear pending.
REQ-019 Writes SHALL update only bytes with req_be set; lanes writing the same word serialize lowest lane first, so the highest lane's bytes win.
REQ-020 Bank reads SHALL have 1-cycle latency; returned data is captured into that lane's slot of resp_rdata.
REQ-021 When no lane remains pending, ISSUE SHALL go to DRAIN; DRAIN pulses resp_valid for exactly one cycle and returns to IDLE.
REQ-022 Latency: with R conflict rounds (R = max lanes per bank, min 1), resp_valid SHALL be high exactly R+1 cycles after the accepting edge.
REQ-023 resp_rdata SHALL hold its value until the next capture; inactive lanes and all lanes of a write request SHALL read zero.
REQ-024 Empty lane mask SHALL be accepted and complete as R=1 with all-zero resp_rdata and no memory access.
REQ-025 req_valid while req_ready is low SHALL be ignored; the requester holds fields until accepted.

Reset
REQ-026 On rst: state = IDLE, req_ready = 1 the cycle after, resp_valid = 0, resp_rdata = 0, pending = 0.
REQ-027 Memory arrays SHALL NOT be reset; reset mid-ISSUE aborts the request with no response, writes already granted remain, ungranted lanes are dropped.

Configuration
REQ-028 With LMEM_READ_MERGE_EN defined, read lanes with identical bank and index SHALL be granted in the same round as the lowest such lane and receive the same data.
REQ-029 Without LMEM_READ_MERGE_EN, identical-address reads SHALL serialize per REQ-018; write behaviour is identical in both builds.

Verification
REQ-030 Conflict-free read: lanes 0-3 at 0x00,0x04,0x08,0x0C preloaded 0xA0..0xA3 -> resp_valid 2 cycles after accept, rdata lane i = 0xA0+i.
REQ-031 Full conflict: 4 reads at 0x00,0x10,0x20,0x30 (all bank 0) -> resp_valid 5 cycles after accept, correct data per lane.
REQ-032 Broadcast: 4 reads at 0x40 -> resp_valid after 2 cycles with LMEM_READ_MERGE_EN, after 5 without; all lanes same data.
REQ-033 Byte-enable write collision: lane0 0x11111111 be=0xF, lane2 0x22222222 be=0x3, same addr -> readback 0x11112222.
REQ-034 Mask 4'b0000 -> resp_valid 2 cycles after accept, rdata 0, memory unchanged.
REQ-035 rst asserted 2 cycles into a 4-round write -> no resp_valid, req_ready=1 after reset, lanes 0-1 written, lanes 2-3 not.

Source files
------------

// File: rtl/lmem_gather_scatter.sv
// Banked local memory with per-lane gather/scatter and bank-conflict serialization.
// Optional build macro LMEM_READ_MERGE_EN: same-word reads share a single bank access.
module lmem_gather_scatter #(
  parameter int NUM_LANES   = 4,
  parameter int DEPTH_WORDS = 1024,
  parameter int WORD_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [NUM_LANES-1:0]          req_lane_mask,
  input  logic [NUM_LANES*32-1:0]       req_addr,
  input  logic [NUM_LANES*WORD_W-1:0]   req_wdata,
  input  logic [NUM_LANES*WORD_W/8-1:0] req_be,
  output logic                          resp_valid,
  output logic [NUM_LANES*WORD_W-1:0]   resp_rdata
);
  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // ISSUE | granting one pending lane per bank per cycle
  // DRAIN | final read data lands, resp_valid pulses
  localparam int BW   = $clog2(NUM_LANES);
  localparam int IW   = $clog2(DEPTH_WORDS);
  localparam int BE_W = WORD_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state;

  logic                        we_q;
  logic [NUM_LANES*32-1:0]     addr_q;
  logic [NUM_LANES*WORD_W-1:0] wdata_q;
  logic [NUM_LANES*BE_W-1:0]   be_q;
  logic [NUM_LANES-1:0]        pending, rd_cap, lane_gnt, pending_next;
  logic [BW-1:0]               lane_bank [NUM_LANES];
  logic [IW-1:0]               lane_idx  [NUM_LANES];
  logic [NUM_LANES-1:0]        bank_vld;
  logic [BW-1:0]               bank_lane [NUM_LANES];
  logic [WORD_W-1:0]           bank_rd   [NUM_LANES];
  logic [NUM_LANES*WORD_W-1:0] rbuf, rbuf_next;
  logic                        unused_addr;

  assign req_ready   = (state == IDLE);
  assign unused_addr = ^addr_q;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_bank[i] = addr_q[32*i+2 +: BW];
      lane_idx[i]  = addr_q[32*i+2+BW +: IW];
    end
  end

  // Descending scan so the lowest-numbered pending lane wins each bank.
  always_comb begin
    for (int b = 0; b < NUM_LANES; b++) begin
      bank_vld[b]  = 1'b0;
      bank_lane[b] = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
        if (pending[i] && lane_bank[i] == BW'(b)) begin
          bank_vld[b]  = 1'b1;
          bank_lane[b] = BW'(i);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_gnt[i] = pending[i] && (bank_lane[lane_bank[i]] == BW'(i));
`ifdef LMEM_READ_MERGE_EN
      if (pending[i] && !we_q && lane_idx[i] == lane_idx[bank_lane[lane_bank[i]]])
        lane_gnt[i] = 1'b1;
`endif
    end
    pending_next = pending & ~lane_gnt;
  end

  for (genvar b = 0; b < NUM_LANES; b++) begin : g_bank
    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rd_q;
    logic              act;
    logic [IW-1:0]     idx;
    logic [BE_W-1:0]   be;
    logic [WORD_W-1:0] wd;

    assign act = (state == ISSUE) && bank_vld[b] && !rst;
    assign idx = lane_idx[bank_lane[b]];
    assign be  = be_q[int'(bank_lane[b])*BE_W +: BE_W];
    assign wd  = wdata_q[int'(bank_lane[b])*WORD_W +: WORD_W];
    assign bank_rd[b] = rd_q;

    always_ff @(posedge clk) begin
      if (act) begin
        if (we_q) begin
          for (int j = 0; j < BE_W; j++)
            if (be[j]) mem[idx][8*j +: 8] <= wd[8*j +: 8];
        end else begin
          rd_q <= mem[idx];
        end
      end
    end
  end

  always_comb begin
    rbuf_next = rbuf;
    for (int i = 0; i < NUM_LANES; i++)
      if (rd_cap[i]) rbuf_next[WORD_W*i +: WORD_W] = bank_rd[lane_bank[i]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      rd_cap     <= '0;
      rbuf       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else begin
      resp_valid <= 1'b0;
      rd_cap     <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            pending <= req_lane_mask;
            rbuf    <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          pending <= pending_next;
          rd_cap  <= we_q ? '0 : lane_gnt;
          rbuf    <= rbuf_next;
          if (pending_next == '0) state <= DRAIN;
        end
        DRAIN: begin
          rbuf       <= rbuf_next;
          resp_rdata <= rbuf_next;
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lmem_gather_scatter.sv
// Scoreboard bench for lmem_gather_scatter: directed requests, decoupled response monitor.
module tb_lmem_gather_scatter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [3:0]   req_lane_mask = '0;
  logic [127:0] req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [15:0]  req_be = '0;
  logic         resp_valid;
  logic [127:0] resp_rdata;

`ifdef LMEM_READ_MERGE_EN
  localparam int BCAST_LAT = 2;
`else
  localparam int BCAST_LAT = 5;
`endif

  lmem_gather_scatter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_lane_mask(req_lane_mask), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           acc;
    int           lat;
    logic [127:0] rd;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   resp_cnt = 0;
  int   rc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      resp_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=resp_valid required=none cycle=%0d", cyc);
      end else begin
        e = sbq.pop_front();
        chk("latency", 128'(cyc - e.acc), 128'(e.lat));
        chk("rdata", resp_rdata, e.rd);
      end
    end
  end

  task automatic drive(input logic we, input logic [3:0] mask, input logic [127:0] addr,
                       input logic [127:0] wdata, input logic [15:0] be);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b1; req_we = we; req_lane_mask = mask;
    req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_after_accept", 128'(req_ready), 128'(0));
  endtask

  task automatic issue(input logic we, input logic [3:0] mask, input logic [127:0] addr,
                       input logic [127:0] wdata, input logic [15:0] be,
                       input int lat, input logic [127:0] rd);
    int n;
    drive(we, mask, addr, wdata, be);
    sbq.push_back('{acc: cyc, lat: lat, rd: rd});
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout actual=no_resp required=resp_valid");
      sbq.delete();
    end
  endtask

  localparam logic [127:0] A_ADDR = {32'h0C, 32'h08, 32'h04, 32'h00};
  localparam logic [127:0] A_DATA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready", 128'(req_ready), 128'(1));
    chk("reset_resp_valid", 128'(resp_valid), 128'(0));
    chk("reset_rdata", resp_rdata, '0);

    // preload: A at bank0..3 idx0, B on bank0 idx1..4, D on bank0 idx6..9
    issue(1'b1, 4'hF, A_ADDR, A_DATA, 16'hFFFF, 2, '0);
    issue(1'b1, 4'hF, {32'h40, 32'h30, 32'h20, 32'h10},
          {32'hB4, 32'hB3, 32'hB2, 32'hB1}, 16'hFFFF, 5, '0);
    issue(1'b1, 4'hF, {32'h90, 32'h80, 32'h70, 32'h60},
          {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 16'hFFFF, 5, '0);

    issue(1'b0, 4'hF, A_ADDR, '0, '0, 2, A_DATA);
    issue(1'b0, 4'hF, {32'h30, 32'h20, 32'h10, 32'h00}, '0, '0, 5,
          {32'hB3, 32'hB2, 32'hB1, 32'hA0});
    issue(1'b0, 4'hF, {4{32'h40}}, '0, '0, BCAST_LAT, {4{32'hB4}});

    // byte-enable collision: lane2 lands after lane0
    issue(1'b1, 4'b0101, {32'h0, 32'h50, 32'h0, 32'h50},
          {32'h0, 32'h22222222, 32'h0, 32'h11111111}, 16'h030F, 3, '0);
    issue(1'b0, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h50}, '0, '0, 2,
          {96'h0, 32'h11112222});

    issue(1'b0, 4'b0000, A_ADDR, '0, '0, 2, '0);
    issue(1'b1, 4'b0000, A_ADDR, {4{32'hFFFFFFFF}}, 16'hFFFF, 2, '0);
    issue(1'b0, 4'hF, A_ADDR, '0, '0, 2, A_DATA);

    // reset two rounds into a four-round write
    rc = resp_cnt;
    drive(1'b1, 4'hF, {32'h90, 32'h80, 32'h70, 32'h60},
          {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 16'hFFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ready_after_rst", 128'(req_ready), 128'(1));
    chk("rdata_after_rst", resp_rdata, '0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_resp", 128'(resp_cnt), 128'(rc));
    issue(1'b0, 4'hF, {32'h90, 32'h80, 32'h70, 32'h60}, '0, '0, 5,
          {32'hD3, 32'hD2, 32'hC1, 32'hC0});

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
